// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore FSM sequencing the multi-cycle MIPS datapath
// (shared I/D memory, IR, MDR, A/B/ALUOut, one ALU).
// Optional macro MEM_WAIT_EN: IF, MEM_RD and MEM_WR stall until mem_ready=1.
// Without it mem_ready is ignored and every memory state lasts one cycle.
module mips_multicycle_ctrl #(
  parameter int ALU_CTRL_W = 3,
  parameter int STATE_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  pc_write,
  output logic                  pc_write_cond,
  output logic                  pc_en,
  output logic [1:0]            pc_src,
  output logic                  i_or_d,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic                  ir_write,
  output logic [1:0]            reg_dst,
  output logic [1:0]            mem_to_reg,
  output logic                  reg_write,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  inst_done,
  output logic                  illegal
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(3'b000);
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = ALU_CTRL_W'(3'b001);
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(3'b010);
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(3'b110);
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = ALU_CTRL_W'(3'b111);

  typedef enum logic [STATE_W-1:0] {
    S_RST, S_IF, S_ID, S_MEM_ADR, S_MEM_RD, S_WB_LW, S_MEM_WR, S_EX_R,
    S_WB_R, S_BRANCH, S_EX_I, S_WB_I, S_JUMP, S_JAL, S_JR
  } state_t;

  state_t state_q, state_d;

  logic                  r_ok;      // funct is one of the supported R-type ops
  logic                  op_legal;  // whole instruction is supported
  logic [ALU_CTRL_W-1:0] r_alu;     // ALU op for the R-type execute step

  // a memory access in progress completes this cycle
  logic mem_go;
`ifdef MEM_WAIT_EN
  assign mem_go = mem_ready;
`else
  logic mem_ready_unused;
  assign mem_ready_unused = mem_ready;
  assign mem_go = 1'b1;
`endif

  // State register; reset drops straight into RST so no strobe survives it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_RST;
    else      state_q <= state_d;
  end

  // Instruction decode from the IR fields: legality and R-type ALU op
  always_comb begin
    r_alu = ALU_ADD;
    r_ok  = 1'b1;
    case (funct)
      F_ADD:   r_alu = ALU_ADD;
      F_SUB:   r_alu = ALU_SUB;
      F_AND:   r_alu = ALU_AND;
      F_OR:    r_alu = ALU_OR;
      F_SLT:   r_alu = ALU_SLT;
      F_JR:    r_alu = ALU_ADD;
      default: r_ok  = 1'b0;
    endcase
    case (opcode)
      OP_R:                              op_legal = r_ok;
      OP_LW, OP_SW, OP_BEQ, OP_ADDI,
      OP_SLTI, OP_J, OP_JAL:             op_legal = 1'b1;
      default:                           op_legal = 1'b0;
    endcase
  end

  // Next state and per-state control outputs
  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 2'b00;
    mem_to_reg    = 2'b00;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_ctrl      = ALU_ADD;
    inst_done     = 1'b0;
    illegal       = 1'b0;
    case (state_q)
      S_RST: state_d = S_IF;
      S_IF: begin
        // fetch and PC+4 in parallel; PC/IR only commit once memory delivers
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_go) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_ID;
        end
      end
      S_ID: begin
        // speculative branch target PC + (imm<<2) into ALUOut
        alu_src_b = 2'b11;
        illegal   = ~op_legal;
        case (opcode)
          OP_LW, OP_SW:      state_d = S_MEM_ADR;
          OP_R:              state_d = (funct == F_JR) ? S_JR :
                                       (r_ok ? S_EX_R : S_IF);
          OP_BEQ:            state_d = S_BRANCH;
          OP_ADDI, OP_SLTI:  state_d = S_EX_I;
          OP_J:              state_d = S_JUMP;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_IF;
        endcase
      end
      S_MEM_ADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_go) state_d = S_WB_LW;
      end
      S_WB_LW: begin
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        inst_done  = 1'b1;
        state_d    = S_IF;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_go) begin
          inst_done = 1'b1;
          state_d   = S_IF;
        end
      end
      S_EX_R: begin
        alu_src_a = 1'b1;
        alu_ctrl  = r_alu;
        state_d   = S_WB_R;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 2'b01;
        inst_done = 1'b1;
        state_d   = S_IF;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_ctrl      = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
        inst_done     = 1'b1;
        state_d       = S_IF;
      end
      S_EX_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = (opcode == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_d   = S_WB_I;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        inst_done = 1'b1;
        state_d   = S_IF;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_src    = 2'b10;
        inst_done = 1'b1;
        state_d   = S_IF;
      end
      S_JAL: begin
        // PC already holds PC+4 from IF, so it is the link value for r31
        pc_write   = 1'b1;
        pc_src     = 2'b10;
        reg_write  = 1'b1;
        reg_dst    = 2'b10;
        mem_to_reg = 2'b10;
        inst_done  = 1'b1;
        state_d    = S_IF;
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_src    = 2'b11;
        inst_done = 1'b1;
        state_d   = S_IF;
      end
      default: state_d = S_RST;
    endcase
  end

  // PC enable folds the branch condition in
  assign pc_en = pc_write | (pc_write_cond & zero);

endmodule
